fc_param_loader: RTL and testbench
==================================

// Module: fc_param_loader
// PURPOSE
//  Writer side of the fully-connected layer's parameter-load interface.
//  Accepts a word-serial valid/ready stream of ACTIV_BITS-wide words.
//  Assembles all weights, then all biases, into the wide flat buses the FC layer samples.
//  Issues one-cycle load_weights / load_biases strobes once each bus is completely written.
//  Sits between the host/SPI word bridge and the FC layer instance.
// PARAMETERS
//  INPUT_SIZE   160  FC layer inputs per neuron
//  OUTPUT_SIZE  64   FC layer neurons
//  ACTIV_BITS   8    bits per weight/bias word
//  (derived) W_WORDS = OUTPUT_SIZE*INPUT_SIZE, B_WORDS = OUTPUT_SIZE
// PORTS
//  clk          in   1                       single clock, rising edge
//  rst          in   1                       async reset, active-high
//  start        in   1                       begin a load session (sampled in IDLE only)
//  abort        in   1                       cancel session, sync
//  s_data       in   ACTIV_BITS              stream word
//  s_valid      in   1                       s_data valid
//  s_ready      out  1                       loader accepts word this cycle
//  weights_out  out  W_WORDS*ACTIV_BITS      flat weight bus to FC layer weights_in
//  biases_out   out  B_WORDS*ACTIV_BITS      flat bias bus to FC layer biases_in
//  load_weights out  1                       1-cycle strobe, weights_out complete
//  load_biases  out  1                       1-cycle strobe, biases_out complete
//  busy         out  1                       session in progress
//  done         out  1                       1-cycle pulse, session finished
// BEHAVIOUR
//  Reset:
//   - rst asserted: state=IDLE, counters=0.
//   - weights_out, biases_out, s_ready, load_*, busy, done all 0, effective immediately.
//  FSM: IDLE -> LOAD_W -> PULSE_W -> LOAD_B -> PULSE_B -> DONE -> IDLE.
//  Outputs are Moore, decoded from registered state:
//   - s_ready = (LOAD_W | LOAD_B).
//   - load_weights = PULSE_W; load_biases = PULSE_B.
//   - done = DONE.
//   - busy = LOAD_W..PULSE_B.
//  Handshake:
//   - A word is accepted only on s_valid & s_ready at a clk edge.
//   - s_valid while s_ready=0 is ignored; no data is lost or counted.
//  LOAD_W:
//   - Accepted word k (0..W_WORDS-1) is written to weights_out[k*ACTIV_BITS +: ACTIV_BITS].
//   - This gives k = neuron*INPUT_SIZE + input.
//   - Acceptance of word W_WORDS-1 moves the FSM to PULSE_W.
//  PULSE_W: 1 cycle, no acceptance, then LOAD_B with the counter cleared.
//  LOAD_B:
//   - Word k (0..B_WORDS-1) is written to biases_out[k*ACTIV_BITS +: ACTIV_BITS].
//   - The last word moves the FSM to PULSE_B.
//  PULSE_B -> DONE (1 cycle) -> IDLE.
//  Timing with start high at edge 0 and s_valid held high:
//   - s_ready=1 from cycle 1.
//   - load_weights in cycle W_WORDS+1.
//   - load_biases in cycle W_WORDS+B_WORDS+2.
//   - done in cycle W_WORDS+B_WORDS+3.
//  Buses hold their value between sessions; words are overwritten in place, never cleared except by rst.
//  start outside IDLE: ignored.
//  abort:
//   - Any non-IDLE state -> IDLE at the next edge; counters cleared.
//   - No further load_* or done strobes are issued.
//   - Partially written bus words are retained.
//   - abort has priority over start and over word acceptance in the same cycle.
//  Counters are sized for W_WORDS-1 and never wrap within a session.
//  rst mid-session: immediate return to reset values; the next session restarts at word 0.
// TESTING (INPUT_SIZE=2, OUTPUT_SIZE=2, ACTIV_BITS=8: W_WORDS=4, B_WORDS=2)
//  1. Reset values: assert rst -> all outputs 0; start with rst held -> stays IDLE.
//  2. Continuous stream:
//     - Stimulus: start@0, then 11,22,33,44,A0,B0 with s_valid=1.
//     - weights_out=0x44332211 with load_weights@5; biases_out=0xB0A0 with load_biases@8.
//     - done@9, busy 1 in cycles 1..8.
//  3. Gapped s_valid (alternating 1/0):
//     - Same final buses as test 2; strobes one cycle after the respective last accepted word.
//     - s_valid=1 during PULSE_W is not accepted.
//  4. abort after 2 weights:
//     - Next cycle IDLE, busy=0, no load_*/done.
//     - weights_out[15:0]=0x2211 kept.
//     - A fresh session rewrites from word 0.
//  5. start mid-LOAD_B: ignored, no restart; s_valid=1 in IDLE -> s_ready=0, buses unchanged.
//  6. rst asserted asynchronously mid-LOAD_B: outputs 0 without waiting for an edge; next start works normally.

Source files
------------

// File: rtl/fc_param_loader.sv
// fc_param_loader: assembles a word-serial stream into flat FC weight/bias buses and strobes each once complete.
module fc_param_loader #(
  parameter int INPUT_SIZE  = 160,
  parameter int OUTPUT_SIZE = 64,
  parameter int ACTIV_BITS  = 8
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      start,
  input  logic                                      abort,
  input  logic [ACTIV_BITS-1:0]                     s_data,
  input  logic                                      s_valid,
  output logic                                      s_ready,
  output logic [OUTPUT_SIZE*INPUT_SIZE*ACTIV_BITS-1:0] weights_out,
  output logic [OUTPUT_SIZE*ACTIV_BITS-1:0]         biases_out,
  output logic                                      load_weights,
  output logic                                      load_biases,
  output logic                                      busy,
  output logic                                      done
);
  localparam int W_WORDS = OUTPUT_SIZE * INPUT_SIZE;
  localparam int B_WORDS = OUTPUT_SIZE;
  localparam int CW      = W_WORDS > 1 ? $clog2(W_WORDS) : 1;
  typedef enum logic [2:0] {IDLE, LOAD_W, PULSE_W, LOAD_B, PULSE_B, DONE} state_t;
  state_t                         state_q, state_d;
  logic [CW-1:0]                  cnt_q, cnt_d;
  logic [W_WORDS*ACTIV_BITS-1:0]  weights_q, weights_d;
  logic [B_WORDS*ACTIV_BITS-1:0]  biases_q, biases_d;
  logic                           w_last, b_last;
  assign w_last = cnt_q == CW'(W_WORDS - 1);
  assign b_last = cnt_q == CW'(B_WORDS - 1);
  // Abort wins over start and over any word offered in the same cycle.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    weights_d = weights_q;
    biases_d  = biases_q;
    if (abort && state_q != IDLE) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          state_d = LOAD_W;
          cnt_d   = '0;
        end
        LOAD_W: if (s_valid) begin
          weights_d[cnt_q*ACTIV_BITS +: ACTIV_BITS] = s_data;
          cnt_d   = w_last ? '0 : cnt_q + 1'b1;
          state_d = w_last ? PULSE_W : LOAD_W;
        end
        PULSE_W: state_d = LOAD_B;
        LOAD_B: if (s_valid) begin
          biases_d[cnt_q*ACTIV_BITS +: ACTIV_BITS] = s_data;
          cnt_d   = b_last ? '0 : cnt_q + 1'b1;
          state_d = b_last ? PULSE_B : LOAD_B;
        end
        PULSE_B: state_d = DONE;
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      weights_q <= '0;
      biases_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      weights_q <= weights_d;
      biases_q  <= biases_d;
    end
  end
  assign s_ready      = state_q == LOAD_W || state_q == LOAD_B;
  assign load_weights = state_q == PULSE_W;
  assign load_biases  = state_q == PULSE_B;
  assign done         = state_q == DONE;
  assign busy         = state_q inside {LOAD_W, PULSE_W, LOAD_B, PULSE_B};
  assign weights_out  = weights_q;
  assign biases_out   = biases_q;
endmodule

// File: tb/tb_fc_param_loader.sv
// tb_fc_param_loader: directed sessions with a queue scoreboard checking buses at each load strobe.
module tb_fc_param_loader;
  localparam int IS = 2, OS = 2, AB = 8, WW = IS * OS, BW = OS;
  logic clk = 0, rst = 0, start = 0, abort = 0, s_valid = 0;
  logic [AB-1:0] s_data = '0;
  logic s_ready, load_weights, load_biases, busy, done;
  logic [WW*AB-1:0] weights_out;
  logic [BW*AB-1:0] biases_out;
  int errors = 0, checks = 0, cyc = 0;
  int lw_cyc, lb_cyc, dn_cyc, rdy_cyc, busy_n;
  logic [WW*AB-1:0] exp_w[$];
  logic [BW*AB-1:0] exp_b[$];
  bit exp_d[$];
  always #5 clk = ~clk;
  fc_param_loader #(.INPUT_SIZE(IS), .OUTPUT_SIZE(OS), .ACTIV_BITS(AB)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .s_data(s_data), .s_valid(s_valid),
    .s_ready(s_ready), .weights_out(weights_out), .biases_out(biases_out),
    .load_weights(load_weights), .load_biases(load_biases), .busy(busy), .done(done)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
    cyc++;
  endtask
  always @(negedge clk) begin
    logic [WW*AB-1:0] ew;
    logic [BW*AB-1:0] eb;
    if (s_ready && rdy_cyc < 0) rdy_cyc = cyc;
    if (busy) busy_n++;
    if (load_weights) begin
      lw_cyc = cyc;
      if (exp_w.size() == 0) chk("unexpected_load_weights", 64'(load_weights), 64'd0);
      else begin
        ew = exp_w.pop_front();
        chk("weights_bus", 64'(weights_out), 64'(ew));
      end
    end
    if (load_biases) begin
      lb_cyc = cyc;
      if (exp_b.size() == 0) chk("unexpected_load_biases", 64'(load_biases), 64'd0);
      else begin
        eb = exp_b.pop_front();
        chk("biases_bus", 64'(biases_out), 64'(eb));
      end
    end
    if (done) begin
      dn_cyc = cyc;
      if (exp_d.size() == 0) chk("unexpected_done", 64'(done), 64'd0);
      else begin
        void'(exp_d.pop_front());
        chk("done_not_busy", {busy, s_ready}, 64'd0);
      end
    end
  end
  // words[7:0] is the first word sent; cycle 1 is the first cycle after the start edge.
  task automatic stream(input logic [47:0] words, input bit gapped, input int abort_cyc,
                        input int start_cyc, input int ncyc, input bit push_w, input bit push_b);
    int idx;
    bit acc;
    idx = 0;
    lw_cyc = -1; lb_cyc = -1; dn_cyc = -1; rdy_cyc = -1; busy_n = 0;
    if (push_w) exp_w.push_back(words[31:0]);
    if (push_b) begin
      exp_b.push_back(words[47:32]);
      exp_d.push_back(1'b1);
    end
    cyc = 0;
    start = 1;
    s_valid = 0;
    step();
    while (cyc < ncyc) begin
      start = cyc == start_cyc;
      abort = cyc == abort_cyc;
      s_valid = gapped ? (cyc % 2 == 1) : 1'b1;
      s_data = idx < 6 ? words[idx*8 +: 8] : 8'h00;
      acc = s_valid && s_ready && !abort;
      step();
      if (acc) idx++;
      if (abort_cyc >= 0 && cyc == abort_cyc + 1)
        chk("abort_to_idle", {busy, s_ready, load_weights, load_biases, done}, 64'd0);
    end
    start = 0;
    abort = 0;
    s_valid = 0;
  endtask
  initial begin
    lw_cyc = -1; lb_cyc = -1; dn_cyc = -1; rdy_cyc = -1; busy_n = 0;
    start = 1;
    s_valid = 1;
    #1 rst = 1;
    #1;
    chk("reset_buses", {weights_out, biases_out}, 64'd0);
    chk("reset_ctrl", {s_ready, load_weights, load_biases, busy, done}, 64'd0);
    repeat (3) step();
    chk("reset_held_start", {s_ready, busy, done}, 64'd0);
    rst = 0;
    start = 0;
    s_valid = 0;
    step();
    // continuous stream
    stream(48'hB0A0_4433_2211, 0, -1, -1, 12, 1, 1);
    chk("t2_ready_cyc", rdy_cyc, 1);
    chk("t2_lw_cyc", lw_cyc, 5);
    chk("t2_lb_cyc", lb_cyc, 8);
    chk("t2_done_cyc", dn_cyc, 9);
    chk("t2_busy_cycles", busy_n, 8);
    chk("t2_weights", weights_out, 32'h4433_2211);
    chk("t2_biases", biases_out, 16'hB0A0);
    // s_valid alternating, high on odd cycles
    stream(48'hB0A0_4433_2211, 1, -1, -1, 16, 1, 1);
    chk("t3_lw_cyc", lw_cyc, 8);
    chk("t3_lb_cyc", lb_cyc, 12);
    chk("t3_done_cyc", dn_cyc, 13);
    chk("t3_busy_cycles", busy_n, 12);
    chk("t3_weights", weights_out, 32'h4433_2211);
    chk("t3_biases", biases_out, 16'hB0A0);
    // abort after two weights, third word offered on the abort cycle
    stream(48'h0000_0077_6655, 0, 3, -1, 8, 0, 0);
    chk("t4_partial_weights", weights_out, 32'h4433_6655);
    chk("t4_biases_kept", biases_out, 16'hB0A0);
    chk("t4_no_strobes", {lw_cyc != -1, lb_cyc != -1, dn_cyc != -1}, 64'd0);
    stream(48'hD2D1_C4C3_C2C1, 0, -1, -1, 12, 1, 1);
    chk("t4_rewrite_lw_cyc", lw_cyc, 5);
    chk("t4_rewrite_weights", weights_out, 32'hC4C3_C2C1);
    chk("t4_rewrite_biases", biases_out, 16'hD2D1);
    // start mid-LOAD_B, then s_valid held in IDLE
    stream(48'hE2E1_F4F3_F2F1, 0, -1, 6, 14, 1, 1);
    chk("t5_lw_cyc", lw_cyc, 5);
    chk("t5_lb_cyc", lb_cyc, 8);
    chk("t5_done_cyc", dn_cyc, 9);
    chk("t5_idle_ready", {s_ready, busy}, 64'd0);
    chk("t5_weights", weights_out, 32'hF4F3_F2F1);
    chk("t5_biases", biases_out, 16'hE2E1);
    // async reset in LOAD_B after one bias
    stream(48'h9291_8483_8281, 0, -1, -1, 7, 1, 0);
    chk("t6_in_load_b", {busy, s_ready, biases_out}, {2'b11, 16'hE291});
    #2 rst = 1;
    #1;
    chk("t6_async_buses", {weights_out, biases_out}, 64'd0);
    chk("t6_async_ctrl", {s_ready, load_weights, load_biases, busy, done}, 64'd0);
    #2 rst = 0;
    step();
    stream(48'hA2A1_B4B3_B2B1, 0, -1, -1, 12, 1, 1);
    chk("t6_restart_lw_cyc", lw_cyc, 5);
    chk("t6_restart_done_cyc", dn_cyc, 9);
    chk("t6_weights", weights_out, 32'hB4B3_B2B1);
    chk("t6_biases", biases_out, 16'hA2A1);
    chk("scoreboard_drained", exp_w.size() + exp_b.size() + exp_d.size(), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
